pcpi_serial_bridge: RTL and testbench

Segment-serial front end that assembles an INSN_W-bit instruction from SEG_W-bit input segments, issues it to a PCPI coprocessor, and returns the PCPI result over a SEG_W-bit valid/ready output stream. It generalises the fixed 4-bit/32-bit loader with parametrised widths, a per-segment acknowledge, result read-back and a no-claim timeout. It sits between the chip-level pins and the coprocessor unit.

---
 rtl/pcpi_serial_bridge_pkg.sv | 20 ++
 rtl/pcpi_serial_bridge_seg_serializer.sv | 47 ++++
 rtl/pcpi_serial_bridge.sv | 123 ++++++++++++
 tb/tb_pcpi_serial_bridge.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcpi_serial_bridge_pkg.sv
// rtl/pcpi_serial_bridge_pkg.sv - shared state encoding and width helpers for the PCPI serial bridge
package pcpi_serial_bridge_pkg;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Number of segments needed to carry total_w bits
    function automatic int seg_count(input int total_w, input int seg_w);
        return total_w / seg_w;
    endfunction

    // Counter width able to index n items, never narrower than one bit
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pcpi_serial_bridge_seg_serializer.sv
// rtl/pcpi_serial_bridge_seg_serializer.sv - RD_W-wide parallel load, SEG_W-wide valid/ready shift-out
module pcpi_serial_bridge_seg_serializer
    import pcpi_serial_bridge_pkg::*;
#(
    parameter int SEG_W = 4,
    parameter int RD_W  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [RD_W-1:0]  load_data,
    output logic [SEG_W-1:0] tdata,
    output logic             tvalid,
    input  logic             tready,
    output logic             tlast
);

    localparam int SEGS = seg_count(RD_W, SEG_W);
    localparam int CW   = cnt_width(SEGS);

    logic [RD_W-1:0] shreg;
    logic [CW-1:0]   cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg  <= '0;
            cnt    <= '0;
            tvalid <= 1'b0;
        end else if (load) begin
            shreg  <= load_data;
            cnt    <= '0;
            tvalid <= 1'b1;
        end else if (tvalid && tready) begin
            shreg <= shreg >> SEG_W;
            if (tlast) begin
                tvalid <= 1'b0;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign tdata = shreg[SEG_W-1:0];
    assign tlast = (cnt == CW'(SEGS - 1));

endmodule

// File: rtl/pcpi_serial_bridge.sv
// rtl/pcpi_serial_bridge.sv - segment-serial instruction loader, PCPI issue with timeout, serial result return
module pcpi_serial_bridge
    import pcpi_serial_bridge_pkg::*;
#(
    parameter int SEG_W   = 4,
    parameter int INSN_W  = 32,
    parameter int RD_W    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [SEG_W-1:0]  seg_in,
    input  logic              seg_valid,
    output logic              seg_ack,
    output logic              pcpi_valid,
    output logic [INSN_W-1:0] pcpi_insn,
    input  logic              pcpi_ready,
    input  logic              pcpi_wr,
    input  logic              pcpi_wait,
    input  logic [RD_W-1:0]   pcpi_rd,
    output logic [SEG_W-1:0]  out_seg,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              err
);

    localparam int SEGS_IN = seg_count(INSN_W, SEG_W);
    localparam int CW      = cnt_width(SEGS_IN);
    localparam int TW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    generate
        if (INSN_W % SEG_W != 0) begin : g_bad_insn_w
            $error("INSN_W must be a multiple of SEG_W");
        end
        if (RD_W % SEG_W != 0) begin : g_bad_rd_w
            $error("RD_W must be a multiple of SEG_W");
        end
    endgenerate

    state_e         state, state_d;
    logic [CW-1:0]  seg_cnt;
    logic [TW-1:0]  tmo_cnt;
    logic           accept, last_seg, issue_done, tmo_hit, ser_load, ser_tlast;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_LOAD;
        else        state <= state_d;
    end

    // Completion from pcpi_ready is tested before the timeout so it wins a tie
    always_comb begin
        state_d    = state;
        accept     = 1'b0;
        last_seg   = 1'b0;
        issue_done = 1'b0;
        tmo_hit    = 1'b0;
        case (state)
            ST_LOAD: begin
                accept   = seg_valid;
                last_seg = seg_valid && (seg_cnt == CW'(SEGS_IN - 1));
                if (last_seg) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (pcpi_ready) begin
                    issue_done = 1'b1;
                    state_d    = pcpi_wr ? ST_DRAIN : ST_LOAD;
                end else if ((TIMEOUT != 0) && !pcpi_wait && (tmo_cnt == TW'(TIMEOUT - 1))) begin
                    tmo_hit = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_DRAIN: begin
                if (out_valid && out_ready && ser_tlast) state_d = ST_LOAD;
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_cnt    <= '0;
            seg_ack    <= 1'b0;
            pcpi_insn  <= '0;
            pcpi_valid <= 1'b0;
            err        <= 1'b0;
            tmo_cnt    <= '0;
        end else begin
            seg_ack <= accept;
            if (accept) begin
                pcpi_insn[int'(seg_cnt)*SEG_W +: SEG_W] <= seg_in;
                seg_cnt <= last_seg ? '0 : seg_cnt + 1'b1;
            end
            if (last_seg)                   pcpi_valid <= 1'b1;
            else if (issue_done || tmo_hit) pcpi_valid <= 1'b0;
            if (tmo_hit)                           err <= 1'b1;
            else if (accept && (seg_cnt == '0))    err <= 1'b0;
            // Only idle, unclaimed issue cycles advance the watchdog
            if ((state == ST_ISSUE) && !pcpi_ready && !pcpi_wait && !tmo_hit)
                tmo_cnt <= tmo_cnt + 1'b1;
            else
                tmo_cnt <= '0;
        end
    end

    assign ser_load = issue_done && pcpi_wr;
    assign busy     = (state != ST_LOAD) || (seg_cnt != '0);

    pcpi_serial_bridge_seg_serializer #(
        .SEG_W (SEG_W),
        .RD_W  (RD_W)
    ) u_seg_serializer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (ser_load),
        .load_data (pcpi_rd),
        .tdata     (out_seg),
        .tvalid    (out_valid),
        .tready    (out_ready),
        .tlast     (ser_tlast)
    );

endmodule

// File: tb/tb_pcpi_serial_bridge.sv
// tb/tb_pcpi_serial_bridge.sv - randomized self-checking bench for pcpi_serial_bridge
module tb_pcpi_serial_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  seg_in;
    logic        seg_valid, seg_ack, pcpi_valid, pcpi_ready, pcpi_wr, pcpi_wait;
    logic [31:0] pcpi_insn, pcpi_rd;
    logic [3:0]  out_seg;
    logic        out_valid, out_ready, busy, err;

    logic [7:0]  b_seg_in;
    logic        b_seg_valid, b_seg_ack, b_pcpi_valid, b_pcpi_ready, b_pcpi_wr, b_pcpi_wait;
    logic [31:0] b_pcpi_insn;
    logic [15:0] b_pcpi_rd;
    logic [7:0]  b_out_seg;
    logic        b_out_valid, b_out_ready, b_busy, b_err;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pcpi_serial_bridge dut (
        .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .seg_valid(seg_valid), .seg_ack(seg_ack),
        .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn), .pcpi_ready(pcpi_ready), .pcpi_wr(pcpi_wr),
        .pcpi_wait(pcpi_wait), .pcpi_rd(pcpi_rd), .out_seg(out_seg), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .err(err)
    );

    pcpi_serial_bridge #(.SEG_W(8), .INSN_W(32), .RD_W(16), .TIMEOUT(255)) dut_b (
        .clk(clk), .rst_n(rst_n), .seg_in(b_seg_in), .seg_valid(b_seg_valid), .seg_ack(b_seg_ack),
        .pcpi_valid(b_pcpi_valid), .pcpi_insn(b_pcpi_insn), .pcpi_ready(b_pcpi_ready), .pcpi_wr(b_pcpi_wr),
        .pcpi_wait(b_pcpi_wait), .pcpi_rd(b_pcpi_rd), .out_seg(b_out_seg), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .busy(b_busy), .err(b_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_insn(input logic [31:0] insn, input bit gaps);
        int acks = 0;
        for (int k = 0; k < 8; k++) begin
            if (gaps) begin
                int g = $urandom_range(0, 2);
                for (int j = 0; j < g; j++) begin
                    seg_valid = 1'b0;
                    tick();
                    if (seg_ack) acks++;
                    check("load_gap_valid", 32'(pcpi_valid), 0);
                end
            end
            seg_in    = insn[4*k +: 4];
            seg_valid = 1'b1;
            tick();
            if (seg_ack) acks++;
            check("seg_ack", 32'(seg_ack), 1);
            if (k == 0) check("err_clear_seg0", 32'(err), 0);
            check("pcpi_valid_load", 32'(pcpi_valid), (k == 7) ? 1 : 0);
            check("busy_load", 32'(busy), 1);
        end
        seg_valid = 1'b0;
        check("ack_count", acks, 8);
        check("pcpi_insn", pcpi_insn, insn);
    endtask

    task automatic do_issue(input logic [31:0] insn, input bit wr, input logic [31:0] rd, input int nwait);
        for (int i = 0; i < nwait; i++) begin
            pcpi_wait = 1'b1;
            seg_valid = 1'($urandom_range(0, 1));
            seg_in    = 4'($urandom);
            tick();
            check("issue_hold", 32'(pcpi_valid), 1);
            check("issue_insn", pcpi_insn, insn);
            check("issue_ack", 32'(seg_ack), 0);
        end
        seg_valid  = 1'b0;
        pcpi_wait  = 1'b1;
        pcpi_ready = 1'b1;
        pcpi_wr    = wr;
        pcpi_rd    = rd;
        tick();
        pcpi_ready = 1'b0;
        pcpi_wr    = 1'b0;
        pcpi_wait  = 1'b0;
        pcpi_rd    = $urandom;
        check("valid_drop", 32'(pcpi_valid), 0);
        check("out_valid_start", 32'(out_valid), 32'(wr));
        check("busy_after_issue", 32'(busy), 32'(wr));
        check("err_after_issue", 32'(err), 0);
    endtask

    // mode 0: always ready, 1: toggle each cycle, 2: random
    task automatic drain(input logic [31:0] rd, input logic [31:0] insn, input int mode);
        int idx = 0;
        int cyc = 0;
        bit rdy;
        while (idx < 8 && cyc < 200) begin
            check("out_valid_drain", 32'(out_valid), 1);
            check("out_seg", 32'(out_seg), (rd >> (4*idx)) & 32'hF);
            check("busy_drain", 32'(busy), 1);
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 2 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready = rdy;
            seg_valid = 1'($urandom_range(0, 1));
            seg_in    = 4'($urandom);
            tick();
            check("drain_seg_ack", 32'(seg_ack), 0);
            check("drain_insn", pcpi_insn, insn);
            if (rdy) idx++;
            cyc++;
        end
        out_ready = 1'b0;
        seg_valid = 1'b0;
        check("drain_count", idx, 8);
        check("out_valid_end", 32'(out_valid), 0);
        check("busy_end", 32'(busy), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_seg_ack"}, 32'(seg_ack), 0);
        check({tag, "_pcpi_valid"}, 32'(pcpi_valid), 0);
        check({tag, "_pcpi_insn"}, pcpi_insn, 0);
        check({tag, "_out_valid"}, 32'(out_valid), 0);
        check({tag, "_out_seg"}, 32'(out_seg), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_err"}, 32'(err), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ins, rd, bword;
        int n;
        bit wr;

        rst_n = 1'b0; seg_in = '0; seg_valid = 1'b0; pcpi_ready = 1'b0; pcpi_wr = 1'b0;
        pcpi_wait = 1'b0; pcpi_rd = '0; out_ready = 1'b0;
        b_seg_in = '0; b_seg_valid = 1'b0; b_pcpi_ready = 1'b0; b_pcpi_wr = 1'b0;
        b_pcpi_wait = 1'b0; b_pcpi_rd = '0; b_out_ready = 1'b0;
        #2;
        check_reset_outputs("reset");
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        ins = 32'h020000B3;
        load_insn(ins, 1'b0);
        do_issue(ins, 1'b1, 32'hDEADBEEF, 3);
        drain(32'hDEADBEEF, ins, 0);

        ins = $urandom; rd = $urandom;
        load_insn(ins, 1'b1);
        do_issue(ins, 1'b1, rd, 1);
        drain(rd, ins, 1);

        // Unclaimed issue: valid must stay up exactly TIMEOUT cycles
        ins = $urandom;
        load_insn(ins, 1'b0);
        n = 0;
        while (pcpi_valid && n < 400) begin
            tick();
            n++;
        end
        check("timeout_cycles", n, 255);
        check("timeout_err", 32'(err), 1);
        check("timeout_busy", 32'(busy), 0);
        check("timeout_no_result", 32'(out_valid), 0);

        ins = $urandom;
        load_insn(ins, 1'b0);
        do_issue(ins, 1'b0, 32'h0, 1000);

        // Ready arriving on the cycle the watchdog would fire completes normally
        ins = $urandom; rd = $urandom;
        load_insn(ins, 1'b0);
        repeat (254) tick();
        check("pre_tie_valid", 32'(pcpi_valid), 1);
        pcpi_ready = 1'b1; pcpi_wr = 1'b1; pcpi_rd = rd;
        tick();
        pcpi_ready = 1'b0; pcpi_wr = 1'b0;
        check("tie_valid_drop", 32'(pcpi_valid), 0);
        check("tie_err", 32'(err), 0);
        check("tie_out_valid", 32'(out_valid), 1);
        drain(rd, ins, 2);

        // A single claimed cycle restarts the unclaimed count
        ins = $urandom;
        load_insn(ins, 1'b0);
        repeat (200) tick();
        pcpi_wait = 1'b1;
        tick();
        pcpi_wait = 1'b0;
        repeat (200) tick();
        check("wait_clear_valid", 32'(pcpi_valid), 1);
        check("wait_clear_err", 32'(err), 0);
        do_issue(ins, 1'b0, 32'h0, 0);

        // pcpi_ready while loading has no effect
        pcpi_ready = 1'b1; pcpi_wr = 1'b1; pcpi_rd = $urandom;
        tick();
        pcpi_ready = 1'b0; pcpi_wr = 1'b0;
        check("ready_in_load_out_valid", 32'(out_valid), 0);
        check("ready_in_load_busy", 32'(busy), 0);

        // Asynchronous reset in the middle of a load
        seg_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            seg_in = 4'($urandom);
            tick();
        end
        seg_valid = 1'b0;
        check("partial_busy", 32'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        tick();
        rst_n = 1'b1;
        ins = $urandom;
        load_insn(ins, 1'b0);
        do_issue(ins, 1'b0, 32'h0, 0);

        // 8-bit segment, 16-bit result instance
        bword = 32'h020000B3;
        for (int k = 0; k < 4; k++) begin
            b_seg_in = bword[8*k +: 8];
            b_seg_valid = 1'b1;
            tick();
            check("b_seg_ack", 32'(b_seg_ack), 1);
        end
        b_seg_valid = 1'b0;
        check("b_pcpi_valid", 32'(b_pcpi_valid), 1);
        check("b_pcpi_insn", b_pcpi_insn, 32'h020000B3);
        b_pcpi_ready = 1'b1; b_pcpi_wr = 1'b1; b_pcpi_rd = 16'h1234;
        tick();
        b_pcpi_ready = 1'b0; b_pcpi_wr = 1'b0;
        check("b_valid_drop", 32'(b_pcpi_valid), 0);
        check("b_out_valid", 32'(b_out_valid), 1);
        b_out_ready = 1'b1;
        check("b_out_seg0", 32'(b_out_seg), 32'h34);
        tick();
        check("b_out_seg1", 32'(b_out_seg), 32'h12);
        tick();
        b_out_ready = 1'b0;
        check("b_out_valid_end", 32'(b_out_valid), 0);
        check("b_busy_end", 32'(b_busy), 0);

        for (int it = 0; it < 20; it++) begin
            ins = $urandom;
            rd  = $urandom;
            wr  = ($urandom_range(0, 3) != 0);
            load_insn(ins, 1'($urandom_range(0, 1)));
            do_issue(ins, wr, rd, $urandom_range(0, 5));
            if (wr) drain(rd, ins, $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
